ddr_ex_lfsr_gen_chk: RTL and testbench

Multi-lane 8-bit LFSR pattern generator and self-synchronising checker for the DDR SDRAM example traffic driver. The generator produces write data as LANES parallel 8-bit lanes with a programmable feedback polynomial. The checker regenerates expected read data, locks onto the incoming stream, then counts and localises errors per lane. Status feeds the example driver's pass/fail logic.

---
 rtl/ddr_ex_pkg.sv | 23 ++
 rtl/ddr_ex_lfsr_lane.sv | 28 ++
 rtl/ddr_ex_lfsr_gen_chk.sv | 152 +++++++++++++++
 tb/tb_ddr_ex_lfsr_gen_chk.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_ex_pkg.sv
// Shared definitions for the DDR example LFSR pattern generator/checker:
// LFSR step, seed fix-up and checker state encoding.
package ddr_ex_pkg;

  localparam logic [7:0] DEF_POLY = 8'h1D;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_HUNT = 2'd1,
    CHK_LOCK = 2'd2
  } chk_state_e;

  // Galois-style shift: drop bit 7, fold it back in through the tap mask.
  function automatic logic [7:0] lfsr_step(input logic [7:0] d, input logic [7:0] poly);
    return {d[6:0], 1'b0} ^ (d[7] ? poly : 8'h00);
  endfunction

  // An all-zero seed would lock the LFSR at zero forever.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/ddr_ex_lfsr_lane.sv
// One 8-bit generator lane: seed when disabled, else load, else step unless paused.
import ddr_ex_pkg::*;

module ddr_ex_lfsr_lane #(
  parameter logic [7:0] SEED = 8'h01,
  parameter logic [7:0] POLY = DEF_POLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic       pause,
  input  logic [7:0] ldata,
  output logic [7:0] q
);

  // A loaded zero is kept as-is; only seeds are fixed up.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      q <= SEED;
    end else if (load) begin
      q <= ldata;
    end else if (!pause) begin
      q <= lfsr_step(q, POLY);
    end
  end

endmodule

// File: rtl/ddr_ex_lfsr_gen_chk.sv
// Multi-lane LFSR write-data generator plus self-synchronising read-data checker
// that locks onto the incoming stream and counts/localises errors per lane.
import ddr_ex_pkg::*;

module ddr_ex_lfsr_gen_chk #(
  parameter int         LANES    = 4,
  parameter logic [7:0] POLY     = DEF_POLY,
  parameter int         SEED     = 32,
  parameter int         LOCK_CNT = 4,
  parameter int         ERR_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 gen_pause,
  input  logic                 gen_load,
  input  logic [8*LANES-1:0]   gen_ldata,
  output logic [8*LANES-1:0]   gen_data,
  input  logic                 chk_valid,
  input  logic [8*LANES-1:0]   chk_data,
  input  logic                 chk_clear,
  output logic                 chk_locked,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [LANES-1:0]     err_lanes,
  output logic                 err_flag,
  output chk_state_e           chk_state
);

  localparam int MC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

  logic [8*LANES-1:0] seed_word;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam logic [7:0] LSEED = seed_fix(8'((SEED + l) % 256));
    assign seed_word[8*l +: 8] = LSEED;

    ddr_ex_lfsr_lane #(.SEED(LSEED), .POLY(POLY)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .load   (gen_load),
      .pause  (gen_pause),
      .ldata  (gen_ldata[8*l +: 8]),
      .q      (gen_data[8*l +: 8])
    );
  end

  // chk_data is consumed on every clk edge where chk_valid=1; there is no
  // back-pressure, and with chk_valid=0 all checker state holds.
  chk_state_e         state_q, state_d;
  logic [8*LANES-1:0] exp_q, exp_d, exp_step, data_step;
  logic [MC_W-1:0]    mc_q, mc_d;
  logic [LANES-1:0]   lane_mis;
  logic               rec_err;
  logic               locked_q;
  logic [ERR_W-1:0]   err_cnt_q;
  logic [LANES-1:0]   err_lanes_q;

  always_comb begin
    exp_step  = '0;
    data_step = '0;
    lane_mis  = '0;
    for (int l = 0; l < LANES; l++) begin
      exp_step[8*l +: 8]  = lfsr_step(exp_q[8*l +: 8], POLY);
      data_step[8*l +: 8] = lfsr_step(chk_data[8*l +: 8], POLY);
      lane_mis[l]         = (chk_data[8*l +: 8] != exp_q[8*l +: 8]);
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    mc_d    = mc_q;
    rec_err = 1'b0;
    if (!enable) begin
      state_d = CHK_IDLE;
      exp_d   = seed_word;
      mc_d    = '0;
    end else begin
      case (state_q)
        CHK_IDLE: begin
          state_d = CHK_HUNT;
          exp_d   = seed_word;
          mc_d    = '0;
        end
        CHK_HUNT: begin
          if (chk_valid) begin
            if (lane_mis == '0) begin
              exp_d = exp_step;
              if (mc_q == MC_W'(LOCK_CNT - 1)) begin
                state_d = CHK_LOCK;
                mc_d    = '0;
              end else begin
                mc_d = mc_q + MC_W'(1);
              end
            end else begin
              // Resync: assume the received word was correct and follow it.
              exp_d = data_step;
              mc_d  = '0;
            end
          end
        end
        CHK_LOCK: begin
          if (chk_valid) begin
            exp_d   = exp_step;
            rec_err = (lane_mis != '0);
          end
        end
        default: begin
          state_d = CHK_IDLE;
          exp_d   = seed_word;
          mc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CHK_IDLE;
      exp_q    <= seed_word;
      mc_q     <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      mc_q     <= mc_d;
      locked_q <= (state_d == CHK_LOCK);
    end
  end

  // Clear wins over accumulation, but a same-cycle error is still captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q   <= '0;
      err_lanes_q <= '0;
    end else if (chk_clear) begin
      err_cnt_q   <= rec_err ? ERR_W'(1) : '0;
      err_lanes_q <= rec_err ? lane_mis : '0;
    end else if (rec_err) begin
      err_cnt_q   <= (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q : err_cnt_q + ERR_W'(1);
      err_lanes_q <= err_lanes_q | lane_mis;
    end
  end

  assign chk_locked = locked_q;
  assign err_cnt    = err_cnt_q;
  assign err_lanes  = err_lanes_q;
  assign err_flag   = |err_lanes_q;
  assign chk_state  = state_q;

endmodule

// File: tb/tb_ddr_ex_lfsr_gen_chk.sv
// Bench for ddr_ex_lfsr_gen_chk: directed scenarios plus randomized traffic,
// every cycle compared against a lane-array reference model.
module tb_ddr_ex_lfsr_gen_chk;
  import ddr_ex_pkg::*;

  localparam int LANES    = 4;
  localparam int W        = 8 * LANES;
  localparam int LOCK_CNT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, enable, gen_pause, gen_load, chk_valid, chk_clear;
  logic [W-1:0] gen_ldata, chk_data;
  logic [W-1:0] gen_data, gen_data_s;
  logic         chk_locked, chk_locked_s, err_flag, err_flag_s;
  logic [15:0]  err_cnt;
  logic [3:0]   err_cnt_s;
  logic [3:0]   err_lanes, err_lanes_s;
  chk_state_e   chk_state, chk_state_s;

  ddr_ex_lfsr_gen_chk dut (
    .clk(clk), .reset(reset), .enable(enable), .gen_pause(gen_pause),
    .gen_load(gen_load), .gen_ldata(gen_ldata), .gen_data(gen_data),
    .chk_valid(chk_valid), .chk_data(chk_data), .chk_clear(chk_clear),
    .chk_locked(chk_locked), .err_cnt(err_cnt), .err_lanes(err_lanes),
    .err_flag(err_flag), .chk_state(chk_state)
  );

  ddr_ex_lfsr_gen_chk #(.ERR_W(4)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .gen_pause(gen_pause),
    .gen_load(gen_load), .gen_ldata(gen_ldata), .gen_data(gen_data_s),
    .chk_valid(chk_valid), .chk_data(chk_data), .chk_clear(chk_clear),
    .chk_locked(chk_locked_s), .err_cnt(err_cnt_s), .err_lanes(err_lanes_s),
    .err_flag(err_flag_s), .chk_state(chk_state_s)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_gen[LANES];
  logic [7:0] m_exp[LANES];
  int         m_st;       // 0 idle, 1 hunt, 2 lock
  int         m_matches;
  int         m_cnt16, m_cnt4;
  logic [3:0] m_lanes;

  function automatic logic [7:0] ref_step(input logic [7:0] x);
    int v;
    v = (int'(x) * 2) % 256;
    if (int'(x) >= 128) v = v ^ 'h1D;
    return 8'(v);
  endfunction

  function automatic logic [7:0] seed_of(input int l);
    int s;
    s = (32 + l) % 256;
    if (s == 0) s = 1;
    return 8'(s);
  endfunction

  function automatic logic [W-1:0] pack(input logic [7:0] a[LANES]);
    logic [W-1:0] w;
    for (int l = 0; l < LANES; l++) w[8*l +: 8] = a[l];
    return w;
  endfunction

  function automatic chk_state_e st_enum(input int s);
    case (s)
      1:       return CHK_HUNT;
      2:       return CHK_LOCK;
      default: return CHK_IDLE;
    endcase
  endfunction

  task automatic model_edge();
    logic [3:0] mis;
    logic       rec;
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        m_gen[l] = seed_of(l);
        m_exp[l] = seed_of(l);
      end
      m_st = 0; m_matches = 0; m_cnt16 = 0; m_cnt4 = 0; m_lanes = '0;
      return;
    end
    for (int l = 0; l < LANES; l++) begin
      if (!enable)         m_gen[l] = seed_of(l);
      else if (gen_load)   m_gen[l] = gen_ldata[8*l +: 8];
      else if (!gen_pause) m_gen[l] = ref_step(m_gen[l]);
    end
    mis = '0;
    for (int l = 0; l < LANES; l++) mis[l] = (chk_data[8*l +: 8] != m_exp[l]);
    rec = 1'b0;
    if (!enable) begin
      m_st = 0; m_matches = 0;
      for (int l = 0; l < LANES; l++) m_exp[l] = seed_of(l);
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (chk_valid) begin
      if (m_st == 1) begin
        if (mis == '0) begin
          for (int l = 0; l < LANES; l++) m_exp[l] = ref_step(m_exp[l]);
          m_matches++;
          if (m_matches == LOCK_CNT) begin
            m_st = 2; m_matches = 0;
          end
        end else begin
          for (int l = 0; l < LANES; l++) m_exp[l] = ref_step(chk_data[8*l +: 8]);
          m_matches = 0;
        end
      end else begin
        for (int l = 0; l < LANES; l++) m_exp[l] = ref_step(m_exp[l]);
        rec = (mis != '0);
      end
    end
    if (chk_clear) begin
      m_cnt16 = rec ? 1 : 0;
      m_cnt4  = rec ? 1 : 0;
      m_lanes = rec ? mis : 4'b0;
    end else if (rec) begin
      m_cnt16 = (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
      m_cnt4  = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
      m_lanes = m_lanes | mis;
    end
  endtask

  task automatic compare_all();
    check("gen_data",    gen_data,     pack(m_gen));
    check("gen_data_s",  gen_data_s,   pack(m_gen));
    check("chk_locked",  chk_locked,   64'(m_st == 2));
    check("chk_state",   chk_state,    st_enum(m_st));
    check("err_cnt",     err_cnt,      64'(m_cnt16));
    check("err_cnt_s",   err_cnt_s,    64'(m_cnt4));
    check("err_lanes",   err_lanes,    m_lanes);
    check("err_lanes_s", err_lanes_s,  m_lanes);
    check("err_flag",    err_flag,     64'(|m_lanes));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Back to IDLE (clearing counters), then into HUNT with the generator held at seeds.
  task automatic restart();
    enable = 1'b0; chk_clear = 1'b1; chk_valid = 1'b0; gen_load = 1'b0; gen_pause = 1'b0;
    cycle();
    chk_clear = 1'b0; enable = 1'b1; gen_pause = 1'b1;
    cycle();
    gen_pause = 1'b0;
  endtask

  logic [7:0] s[LANES];

  task automatic next_stream(output logic [W-1:0] w);
    w = pack(s);
    for (int l = 0; l < LANES; l++) s[l] = ref_step(s[l]);
  endtask

  initial begin
    logic [W-1:0] w;
    int r;
    reset = 1'b1; enable = 1'b0; gen_pause = 1'b0; gen_load = 1'b0; gen_ldata = '0;
    chk_valid = 1'b0; chk_data = '0; chk_clear = 1'b0;
    cycle();
    cycle();
    check("rst_gen_word", gen_data, 32'h23222120);
    check("rst_locked",   chk_locked, 1'b0);
    check("rst_err_cnt",  err_cnt, 16'h0);
    check("rst_state",    chk_state, CHK_IDLE);

    // Generator free-run, pause, load.
    reset = 1'b0; enable = 1'b1;
    cycle(); check("lane0_seq1", gen_data[7:0], 8'h40);
    cycle(); check("lane0_seq2", gen_data[7:0], 8'h80);
    cycle(); check("lane0_seq3", gen_data[7:0], 8'h1D);
    gen_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(); check("pause_hold", gen_data[7:0], 8'h1D);
    end
    gen_pause = 1'b0; gen_load = 1'b1; gen_ldata = 32'hA5A5A5A5;
    cycle(); check("load_word", gen_data, 32'hA5A5A5A5);
    gen_load = 1'b0;
    cycle(); check("load_step", gen_data, 32'h57575757);

    // Loopback from the seed word: lock after exactly LOCK_CNT valid words.
    restart();
    chk_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk_data = pack(m_gen);
      cycle();
      check("loop_lock", chk_locked, 64'(k == 4));
    end
    check("loop_err_cnt", err_cnt, 16'h0);

    // Stream from an arbitrary 8'h5A per lane: one resync word, then lock.
    restart();
    for (int l = 0; l < LANES; l++) s[l] = 8'h5A;
    chk_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      next_stream(w); chk_data = w;
      cycle();
      check("resync_lock", chk_locked, 64'(k == 5));
    end
    check("resync_err_cnt", err_cnt, 16'h0);

    // Single-bit error in lane 2 while locked.
    next_stream(w); chk_data = w ^ 32'h0008_0000;
    cycle();
    check("err1_cnt",    err_cnt,    16'h1);
    check("err1_lanes",  err_lanes,  4'b0100);
    check("err1_flag",   err_flag,   1'b1);
    check("err1_locked", chk_locked, 1'b1);
    for (int k = 0; k < 3; k++) begin
      next_stream(w); chk_data = w;
      cycle();
    end
    check("err1_after", err_cnt, 16'h1);
    chk_clear = 1'b1;
    next_stream(w); chk_data = w ^ 32'h0000_0001;
    cycle();
    check("clr_err_cnt",   err_cnt,   16'h1);
    check("clr_err_lanes", err_lanes, 4'b0001);
    next_stream(w); chk_data = w;
    cycle();
    check("clr_only_cnt", err_cnt, 16'h0);
    check("clr_only_flag", err_flag, 1'b0);
    chk_clear = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 29) != 0);
      gen_load  = ($urandom_range(0, 15) == 0);
      gen_ldata = $urandom;
      gen_pause = ($urandom_range(0, 3) == 0);
      chk_clear = ($urandom_range(0, 39) == 0);
      chk_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r <= 5)      chk_data = pack(m_exp);
      else if (r == 6) chk_data = pack(m_exp) ^ (32'h1 << $urandom_range(0, 31));
      else if (r == 7) chk_data = pack(m_gen);
      else             chk_data = $urandom;
      cycle();
    end
    chk_clear = 1'b0; gen_load = 1'b0;

    // Saturation of a 4-bit counter after 20 bad words in LOCK.
    restart();
    for (int l = 0; l < LANES; l++) s[l] = 8'h5A;
    chk_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_stream(w); chk_data = w;
      cycle();
    end
    check("sat_locked", chk_locked, 1'b1);
    for (int k = 0; k < 20; k++) begin
      next_stream(w); chk_data = w ^ (32'h1 << $urandom_range(0, 31));
      cycle();
    end
    check("sat_cnt4",  err_cnt_s, 4'hF);
    check("sat_cnt16", err_cnt,   16'd20);

    // Reset mid-stream overrides everything else.
    reset = 1'b1; chk_valid = 1'b1; enable = 1'b1; chk_data = $urandom;
    cycle();
    check("mid_rst_gen",    gen_data,   32'h23222120);
    check("mid_rst_locked", chk_locked, 1'b0);
    check("mid_rst_cnt",    err_cnt,    16'h0);
    check("mid_rst_cnt4",   err_cnt_s,  4'h0);
    check("mid_rst_lanes",  err_lanes,  4'h0);
    check("mid_rst_flag",   err_flag,   1'b0);
    check("mid_rst_state",  chk_state,  CHK_IDLE);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
